uart_rx_mini: RTL
=================

Name: uart_rx_mini

Overview:
Receive-side companion to the APB UART transmitter. It over-samples the incoming serial line, deserialises 8N1 frames into bytes and buffers them in a small FIFO. It exposes data and status over the same APB slave port style, and raises irq/rts flow control to the CPU and the remote sender. It sits between the pad-level rx pin and the peripheral APB bus.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); must be >= 4.
FIFO_DEPTH, 4, RX FIFO entries; power of two, >= 2.

Ports:
clk  in  1  single system clock
rst  in  1  reset; synchronous, active-high
apbs_psel  in  1  APB select
apbs_penable  in  1  APB access phase
apbs_pwrite  in  1  APB write
apbs_paddr  in  16  byte address; only [3:2] decoded
apbs_pwdata  in  32  write data
apbs_prdata  out  32  read data
apbs_pready  out  1  always 1 (zero wait states)
apbs_pslverr  out  1  always 0
rx  in  1  serial input, asynchronous, idle high
rts  out  1  active-low request-to-send toward the remote transmitter
irq  out  1  level interrupt
dreq  out  1  DMA request

Behaviour:
- Reset: apbs_prdata=0, rts=1, irq=0, dreq=0, FIFO empty, sticky flags clear, FSM=IDLE, synchroniser flops=1.
- rx passes through a 2-flop synchroniser. All FSM decisions use the synchronised signal rxs.
- Bit counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 on every FSM transition.
- IDLE: rxs==0 -> START.
- START: at count CLKS_PER_BIT/2-1, if rxs==0 -> DATA and reset the bit index to 0. Otherwise glitch -> IDLE with no flag set.
- DATA: every CLKS_PER_BIT cycles (mid-bit), shift rxs into the shift register, LSB first. After the 8th sample -> STOP.
- STOP: sample at mid-bit.
  - rxs==1: push the byte and -> IDLE.
  - rxs==0: set FERR (sticky), discard the byte, -> WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1, then -> IDLE. A held break therefore produces one FERR, not repeated frames.
- Push: occurs on the cycle the stop sample is taken.
  - If the FIFO is full and no pop happens in the same cycle: set OVR (sticky) and drop the new byte.
  - Push and pop in the same cycle when full: both succeed, OVR stays clear.
- Register map (paddr[3:2]):
  - 0 DATA, read: {23'b0, nonempty, head[7:0]}, combinational from the FIFO head. The access phase (psel&penable&!pwrite) pops if non-empty. Reading while empty returns 0 and does not pop.
  - 1 STATUS, read: {28'b0, FERR, OVR, full, nonempty}, no side effects. Write: pwdata[2] clears OVR, pwdata[3] clears FERR. A set event in the same cycle as a clear wins (flag stays 1).
  - 2/3: read 0; writes ignored.
  - Writes to DATA are ignored.
- irq = nonempty | OVR | FERR, registered (one cycle after the cause).
- dreq = nonempty, registered.
- rts: 0 while FIFO free entries >= 2, else 1; registered.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

Optional Feature:
UART_RX_MAJORITY_EN:
- Defined: each START/DATA/STOP decision uses a 2-of-3 majority of rxs sampled at mid-bit-1, mid-bit and mid-bit+1. The decision is made at mid-bit+1, so the push moves one cycle later.
- Undefined: single sample at mid-bit as above.

Decomposition:
- Package uart_pkg: register offsets (UART_DATA=0, UART_STATUS=1), STATUS bit indices, FSM state encoding (IDLE, START, DATA, STOP, WAIT_HIGH).
- One sub-module, uart_rx_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised by depth and width.

Test Plan:
All scenarios use CLKS_PER_BIT=8, FIFO_DEPTH=4.
- Reset released, line idle: rts=0, irq=0. Send 0xA5 8N1 -> STATUS reads 0x1; DATA read returns 0x1A5; STATUS then reads 0x0; irq falls.
- Send 0x00,0x11,0x22,0x33,0x44 without reading -> rts=1 after the 3rd byte, OVR set after the 5th. DATA reads return 0x100,0x111,0x122,0x133, then 0x000.
- Frame 0x55 with stop bit 0 -> FERR=1, FIFO empty. Hold rx low 40 cycles then high -> still one FERR. Write STATUS 0x8 -> FERR=0.
- 3-cycle low glitch on idle rx -> no push, no flags, FSM back in IDLE.
- FIFO full, DATA pop coincident with the 5th stop sample -> OVR=0, count stays 4.
- UART_RX_MAJORITY_EN defined: 1-cycle inverted spike at each mid-bit of 0x3C -> 0x3C received intact. Without the macro, the same stimulus yields 0xC3.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit positions and receiver FSM encoding
package uart_pkg;
    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam int STAT_NE   = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_FERR = 3;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_e;
endpackage

// File: rtl/uart_rx_mini_if.sv
// uart_rx_mini_if: APB slave bundle of the UART receiver
interface uart_rx_mini_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO; a push into a full FIFO only lands when a pop frees the slot
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;
    assign do_push = push_i & (!full_o | pop_i);
    assign do_pop  = pop_i & !empty_o;
    assign full_o  = count_q == (AW+1)'(DEPTH);
    assign empty_o = count_q == '0;
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= do_push ? wptr_q + 1'b1 : wptr_q;
            rptr_q  <= do_pop ? rptr_q + 1'b1 : rptr_q;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/uart_rx_mini.sv
// uart_rx_mini: 8N1 serial receiver with RX FIFO, APB status/data access and irq/dreq/rts.
// UART_RX_MAJORITY_EN: 2-of-3 vote around mid-bit, decisions land one cycle later.
module uart_rx_mini
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst,
    uart_rx_mini_if.slave   apbs,
    input  logic            rx,
    output logic            rts,
    output logic            irq,
    output logic            dreq
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    rx_state_e        state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       sh_q, head;
    logic             rx_s1_q, rxs_q, bit_val, bit_pt, start_pt, stop_pt;
    logic             push, pop, full, empty, rd, wr_stat, ovr_q, ferr_q;
    logic [CNTW-1:0]  count;
    logic [31:0]      status;
    logic [1:0]       addr;
    logic             unused;
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] START_AT = CW'(CLKS_PER_BIT / 2);
    logic rxs_p1_q, rxs_p2_q;
    always_ff @(posedge clk) begin
        if (rst) {rxs_p2_q, rxs_p1_q} <= 2'b11;
        else {rxs_p2_q, rxs_p1_q} <= {rxs_p1_q, rxs_q};
    end
    assign bit_val = (rxs_q & rxs_p1_q) | (rxs_q & rxs_p2_q) | (rxs_p1_q & rxs_p2_q);
`else
    localparam logic [CW-1:0] START_AT = CW'(CLKS_PER_BIT / 2 - 1);
    assign bit_val = rxs_q;
`endif
    always_ff @(posedge clk) begin
        if (rst) {rx_s1_q, rxs_q} <= 2'b11;
        else {rx_s1_q, rxs_q} <= {rx, rx_s1_q};
    end
    assign bit_pt   = cnt_q == LAST;
    assign start_pt = state_q == START && cnt_q == START_AT;
    assign stop_pt  = state_q == STOP && bit_pt;
    assign push     = stop_pt & bit_val;
    // The counter free-runs within a state and restarts at zero on every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
        end else begin
            cnt_q <= bit_pt ? '0 : cnt_q + 1'b1;
            case (state_q)
                IDLE: if (!rxs_q) begin
                    state_q <= START;
                    cnt_q   <= '0;
                end
                START: if (start_pt) begin
                    state_q <= bit_val ? IDLE : DATA;
                    cnt_q   <= '0;
                    idx_q   <= '0;
                end
                DATA: if (bit_pt) begin
                    sh_q  <= {bit_val, sh_q[7:1]};
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == 3'd7) state_q <= STOP;
                end
                STOP: if (bit_pt) state_q <= bit_val ? IDLE : WAIT_HIGH;
                WAIT_HIGH: if (rxs_q) begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .wdata_i(sh_q),
        .rdata_o(head), .full_o(full), .empty_o(empty), .count_o(count)
    );
    assign addr    = apbs.paddr[3:2];
    assign rd      = apbs.psel & apbs.penable & !apbs.pwrite;
    assign wr_stat = apbs.psel & apbs.penable & apbs.pwrite & (addr == UART_STATUS);
    assign pop     = rd & (addr == UART_DATA) & !empty;
    always_comb begin
        status            = '0;
        status[STAT_NE]   = !empty;
        status[STAT_FULL] = full;
        status[STAT_OVR]  = ovr_q;
        status[STAT_FERR] = ferr_q;
    end
    assign apbs.prdata  = addr == UART_DATA ? {23'b0, !empty, empty ? 8'h00 : head} :
                          addr == UART_STATUS ? status : 32'h0;
    assign apbs.pready  = 1'b1;
    assign apbs.pslverr = 1'b0;
    assign unused = ^{apbs.paddr[15:4], apbs.paddr[1:0], apbs.pwdata[31:4], apbs.pwdata[1:0]};
    // A flag set in the same cycle as its clear wins
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            irq    <= 1'b0;
            dreq   <= 1'b0;
            rts    <= 1'b1;
        end else begin
            ovr_q  <= (push & full & !pop) | (ovr_q & !(wr_stat & apbs.pwdata[STAT_OVR]));
            ferr_q <= (stop_pt & !bit_val) | (ferr_q & !(wr_stat & apbs.pwdata[STAT_FERR]));
            irq    <= !empty | ovr_q | ferr_q;
            dreq   <= !empty;
            rts    <= count > CNTW'(FIFO_DEPTH - 2);
        end
    end
endmodule
